// File: rtl/if_id_queue.sv
// if_id_queue: prefetch queue between fetch and decode.
// Circular buffer of DEPTH {PC, instruction} pairs with show-ahead head output,
// single-cycle flush, asynchronous active-low reset.
// Optional same-cycle bypass when empty: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instruction,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] pc_mem  [DEPTH];
  logic [WIDTH-1:0] ins_mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // Handshake decode and show-ahead head selection.
  always_comb begin
    in_ready        = ~full;
    bypass          = 1'b0;
    out_valid       = ~empty;
    out_pc          = pc_mem[rd_ptr];
    out_instruction = ins_mem[rd_ptr];
`ifdef IF_ID_QUEUE_BYPASS_EN
    // Empty queue forwards the fetch pair; it is only consumed (not stored)
    // when decode takes it this cycle.
    if (empty) begin
      out_valid       = in_valid & ~flush;
      out_pc          = in_pc;
      out_instruction = in_instruction;
      bypass          = in_valid & out_ready & ~flush;
    end
`endif
    push = in_valid & in_ready & ~flush & ~bypass;
    // Pop is qualified on stored occupancy so a bypassed pair never pops.
    pop  = ~empty & out_ready & ~flush;
  end

  // Storage write; contents are intentionally not reset or cleared on flush.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= in_pc;
      ins_mem[wr_ptr] <= in_instruction;
    end
  end

  // Pointer and occupancy update; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

endmodule
